// File: rtl/noc_defs.sv
// noc_defs: shared router constants (port codes, flit types, mesh size) and arbiter types
package noc_defs;
    localparam int NUM_PORTS   = 5;
    localparam int FLIT_TYPE_W = 2;
    localparam int SEL_W       = 3;
    localparam int X_NODE_NUM  = 4;
    localparam int Y_NODE_NUM  = 4;
    localparam int X_NODE_W    = $clog2(X_NODE_NUM);
    localparam int Y_NODE_W    = $clog2(Y_NODE_NUM);
    localparam logic [SEL_W-1:0] PORT_L = 3'd1;
    localparam logic [SEL_W-1:0] PORT_E = 3'd2;
    localparam logic [SEL_W-1:0] PORT_N = 3'd3;
    localparam logic [SEL_W-1:0] PORT_W = 3'd4;
    localparam logic [SEL_W-1:0] PORT_S = 3'd5;
    typedef enum logic [FLIT_TYPE_W-1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HDR    = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;
    typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;
    function automatic logic is_head(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FT_HDR) || (t == FT_SINGLE);
    endfunction
    function automatic logic is_last(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
        return (p >= SEL_W'(NUM_PORTS - 1)) ? '0 : p + 3'd1;
    endfunction
endpackage

// File: rtl/rr_pick5.sv
// rr_pick5: combinational round-robin picker over five requesters starting at ptr
module rr_pick5
    import noc_defs::*;
(
    input  logic [NUM_PORTS-1:0] elig,
    input  logic [SEL_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] win,
    output logic                 valid
);
    logic [SEL_W-1:0] base;
    assign base  = (ptr < SEL_W'(NUM_PORTS)) ? ptr : '0;
    assign valid = |elig;
    // scan in reverse priority so the earliest eligible index after base is written last
    always_comb begin
        win = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--)
            if (elig[(int'(base) + k) % NUM_PORTS])
                win = NUM_PORTS'(1) << ((int'(base) + k) % NUM_PORTS);
    end
endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: per-output round-robin packet arbiter; NOC_ARB_PKT_CNT_EN adds pkt_count/starve
module noc_output_arbiter
    import noc_defs::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*FLIT_TYPE_W-1:0] flit_type_in,
    input  logic                           out_ready,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [SEL_W-1:0]               xbar_sel,
    output logic                           out_valid,
    output logic                           busy
`ifdef NOC_ARB_PKT_CNT_EN
    ,
    output logic [15:0]                    pkt_count,
    output logic [NUM_PORTS-1:0]           starve
`endif
);
    arb_state_t state, state_nxt;
    logic [NUM_PORTS-1:0] elig, win, grant_nxt;
    logic [SEL_W-1:0] rr_ptr, ptr_nxt, sel_nxt, win_sel, g_idx;
    logic [FLIT_TYPE_W-1:0] g_type;
    logic win_vld, busy_nxt, transfer, release_pkt;

    rr_pick5 u_pick (
        .elig  (elig),
        .ptr   (rr_ptr),
        .win   (win),
        .valid (win_vld)
    );

    // only packet heads (HDR or SINGLE) may compete for an idle output
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            elig[i] = req[i] & is_head(flit_type_in[FLIT_TYPE_W*i +: FLIT_TYPE_W]);
    end

    // decode the granted input's index/type and the winner's crossbar code
    always_comb begin
        g_type  = '0;
        g_idx   = '0;
        win_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                g_type = flit_type_in[FLIT_TYPE_W*i +: FLIT_TYPE_W];
                g_idx  = SEL_W'(i);
            end
            if (win[i])
                win_sel = SEL_W'(i + 1);
        end
    end

    assign out_valid   = |(grant & req);
    assign transfer    = out_valid & out_ready;
    assign release_pkt = (state == ST_BUSY) & transfer & is_last(g_type);

    // next-state: arbitrate when idle, hold until the packet's last flit transfers when busy
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = xbar_sel;
        busy_nxt  = busy;
        ptr_nxt   = rr_ptr;
        if (state == ST_IDLE) begin
            if (win_vld) begin
                state_nxt = ST_BUSY;
                grant_nxt = win;
                sel_nxt   = win_sel;
                busy_nxt  = 1'b1;
            end
        end else if (release_pkt) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            sel_nxt   = '0;
            busy_nxt  = 1'b0;
            ptr_nxt   = next_ptr(g_idx);
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            xbar_sel <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            xbar_sel <= sel_nxt;
            busy     <= busy_nxt;
            rr_ptr   <= ptr_nxt;
        end
    end

`ifdef NOC_ARB_PKT_CNT_EN
    logic [3:0] wait_cnt [NUM_PORTS];

    // completed-packet counter and sticky starvation flags after 16 waiting cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
            starve    <= '0;
            for (int i = 0; i < NUM_PORTS; i++)
                wait_cnt[i] <= '0;
        end else begin
            if (release_pkt)
                pkt_count <= pkt_count + 16'd1;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (elig[i] & ~grant[i]) begin
                    if (wait_cnt[i] == 4'd15)
                        starve[i] <= 1'b1;
                    else
                        wait_cnt[i] <= wait_cnt[i] + 4'd1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: randomized and directed checks against a packet-level reference model
module tb_noc_output_arbiter;
    localparam logic [1:0] BODY = 2'b00, TAIL = 2'b01, HDR = 2'b10, SGL = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic [9:0] flit_type_in = '0;
    logic       out_ready = 1'b0;
    logic [4:0] grant;
    logic [2:0] xbar_sel;
    logic       out_valid;
    logic       busy;
`ifdef NOC_ARB_PKT_CNT_EN
    logic [15:0] pkt_count;
    logic [4:0]  starve;
`endif

    noc_output_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .flit_type_in (flit_type_in),
        .out_ready    (out_ready),
        .grant        (grant),
        .xbar_sel     (xbar_sel),
        .out_valid    (out_valid),
        .busy         (busy)
`ifdef NOC_ARB_PKT_CNT_EN
        ,
        .pkt_count    (pkt_count),
        .starve       (starve)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int owner = -1;
    int ptr = 0;
    int pkts = 0;
    int order[$];

    task automatic check(input string tag, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] ftype(input int i);
        return flit_type_in[2*i +: 2];
    endfunction

    task automatic drive(input logic [4:0] r, input logic [9:0] t, input logic rdy);
        req = r;
        flit_type_in = t;
        out_ready = rdy;
    endtask

    function automatic logic [9:0] at(input int i, input logic [1:0] t);
        return 10'(t) << (2*i);
    endfunction

    task automatic compare(input string tag);
        check({tag, ".grant"}, int'(grant), owner < 0 ? 0 : (1 << owner));
        check({tag, ".sel"}, int'(xbar_sel), owner + 1);
        check({tag, ".busy"}, int'(busy), int'(owner >= 0));
        check({tag, ".valid"}, int'(out_valid), int'(owner >= 0 && req[owner]));
    endtask

    task automatic model_edge();
        if (owner < 0) begin
            for (int k = 0; k < 5; k++) begin
                int i;
                i = (ptr + k) % 5;
                if (req[i] && (ftype(i) == HDR || ftype(i) == SGL)) begin
                    owner = i;
                    break;
                end
            end
        end else if (req[owner] && out_ready && (ftype(owner) == TAIL || ftype(owner) == SGL)) begin
            ptr = (owner + 1) % 5;
            owner = -1;
            pkts++;
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        compare(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        owner = -1;
        ptr = 0;
        pkts = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(5'b11111, {5{HDR}}, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.grant", int'(grant), 0);
        check("rst.sel", int'(xbar_sel), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.valid", int'(out_valid), 0);
        rst_n = 1'b1;
        model_edge();
        @(posedge clk);
        #1;
        check("rel.grant", int'(grant), 1);
        check("rel.sel", int'(xbar_sel), 1);

        do_reset();
        drive(5'b00010, at(1, HDR), 1'b1);
        step("sp_hdr");
        check("sp.grant", int'(grant), 5'b00010);
        drive(5'b00010, at(1, BODY), 1'b1);
        step("sp_body");
        drive(5'b00010, at(1, TAIL), 1'b1);
        step("sp_tail");
        check("sp.busy_clr", int'(busy), 0);
        drive(5'b11111, {5{HDR}}, 1'b1);
        step("sp_next");
        check("sp.ptr2", int'(grant), 5'b00100);

        do_reset();
        order.delete();
        drive(5'b11111, {5{SGL}}, 1'b1);
        for (int c = 0; c < 12; c++) begin
            step("rr");
            if (grant != 0) order.push_back(int'(xbar_sel) - 1);
        end
        check("rr.count", order.size(), 6);
        for (int k = 0; k < order.size() && k < 6; k++)
            check("rr.order", order[k], k % 5);

        do_reset();
        drive(5'b01000, at(3, HDR), 1'b1);
        step("bp_hdr");
        drive(5'b01000, at(3, BODY), 1'b1);
        step("bp_body");
        drive(5'b01000, at(3, TAIL), 1'b0);
        for (int c = 0; c < 4; c++) begin
            step("bp_stall");
            check("bp.grant", int'(grant), 5'b01000);
            check("bp.busy", int'(busy), 1);
        end
        out_ready = 1'b1;
        step("bp_tail");
        check("bp.release", int'(busy), 0);

        do_reset();
        drive(5'b00100, at(2, HDR), 1'b1);
        step("np_hdr");
        drive(5'b10100, at(2, BODY) | at(4, HDR), 1'b1);
        step("np_b1");
        check("np.hold", int'(grant), 5'b00100);
        step("np_b2");
        check("np.hold", int'(grant), 5'b00100);
        drive(5'b10100, at(2, TAIL) | at(4, HDR), 1'b1);
        step("np_tail");
        check("np.idle", int'(grant), 0);
        drive(5'b10000, at(4, HDR), 1'b1);
        step("np_s");
        check("np.s_grant", int'(grant), 5'b10000);

        do_reset();
        drive(5'b00100, at(2, HDR), 1'b1);
        step("mr_hdr");
        drive(5'b00100, at(2, BODY), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr.grant", int'(grant), 0);
        check("mr.sel", int'(xbar_sel), 0);
        check("mr.busy", int'(busy), 0);
        check("mr.valid", int'(out_valid), 0);
`ifdef NOC_ARB_PKT_CNT_EN
        check("mr.pkt", int'(pkt_count), 0);
`endif
        drive('0, '0, 1'b0);
        owner = -1;
        ptr = 0;
        pkts = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(5'b00001, at(0, SGL), 1'b1);
        step("mr_after");
        check("mr.ptr0", int'(grant), 5'b00001);

        for (int c = 0; c < 1500; c++) begin
            drive(5'($urandom), 10'($urandom), ($urandom_range(0, 3) != 0));
            step("rnd");
        end
        drive('0, '0, 1'b0);
        step("end");
`ifdef NOC_ARB_PKT_CNT_EN
        check("pkt_count", int'(pkt_count), pkts % 65536);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
